fir_sample_packer: RTL and testbench

- Upstream feeder for the FIR filter block.
- Accepts a stream of 16-bit signed samples over a valid/ready handshake and packs SAMPLES_NUM of them into one frame word.
- Double-buffers frames (ping-pong), so collection continues while the filter is busy.
- Launches the filter with a one-cycle start pulse and holds the packed frame stable on a registered bus until the filter has loaded it.

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_frame_bank.sv | 52 +++++
 rtl/fir_sample_packer.sv | 133 +++++++++++++
 tb/tb_fir_sample_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types for the FIR filter, its sample packer and its downstream consumer
package fir_pkg;

  localparam int IN_SAMPLE_WIDTH  = 16;
  localparam int OUT_SAMPLE_WIDTH = 32;

  typedef logic signed [IN_SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    HOLD  = 2'd2
  } launch_state_t;

endpackage

// File: rtl/fir_frame_bank.sv
// rtl/fir_frame_bank.sv - one frame bank of SAMPLES_NUM sample lanes with a full flag
module fir_frame_bank
  import fir_pkg::*;
#(
  parameter int SAMPLES_NUM = 4,
  parameter int LANE_W      = 2
) (
  input  logic                                 clkIn,
  input  logic                                 nResetIn,
  input  logic                                 we_i,
  input  logic [LANE_W-1:0]                    lane_i,
  input  sample_t                              data_i,
  input  logic                                 set_full_i,
  input  logic                                 clr_full_i,
  input  logic                                 flush_i,
  output logic [SAMPLES_NUM*IN_SAMPLE_WIDTH-1:0] frame_o,
  output logic                                 full_o
);

  logic [SAMPLES_NUM*IN_SAMPLE_WIDTH-1:0] frame_q;
  logic                                   full_q;

  // Lane storage: the addressed lane captures the incoming sample.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      frame_q <= '0;
    end else begin
      for (int k = 0; k < SAMPLES_NUM; k++) begin
        if (we_i && (lane_i == LANE_W'(k))) begin
          frame_q[k*IN_SAMPLE_WIDTH +: IN_SAMPLE_WIDTH] <= data_i;
        end
      end
    end
  end

  // Full flag: flush wins; set and clear never target the same bank together.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      full_q <= 1'b0;
    end else if (flush_i) begin
      full_q <= 1'b0;
    end else if (set_full_i) begin
      full_q <= 1'b1;
    end else if (clr_full_i) begin
      full_q <= 1'b0;
    end
  end

  assign frame_o = frame_q;
  assign full_o  = full_q;

endmodule

// File: rtl/fir_sample_packer.sv
// rtl/fir_sample_packer.sv - ping-pong sample packer that launches frames into the FIR filter
module fir_sample_packer
  import fir_pkg::*;
#(
  parameter int SAMPLES_NUM  = 4,
  parameter int SAMPLE_WIDTH = IN_SAMPLE_WIDTH
) (
  input  logic                              clkIn,
  input  logic                              nResetIn,
  input  logic [SAMPLE_WIDTH-1:0]           sampleIn,
  input  logic                              sampleValidIn,
  output logic                              sampleReadyOut,
  input  logic                              flushIn,
  input  logic                              firBusyIn,
  output logic                              firStartOut,
  output logic [SAMPLE_WIDTH*SAMPLES_NUM-1:0] firDataOut,
  output logic [1:0]                        pendingOut
);

  localparam int LANE_W  = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
  localparam int FRAME_W = SAMPLE_WIDTH * SAMPLES_NUM;

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
  launch_state_t     state_q, state_d;
  logic [FRAME_W-1:0] fir_data_q, fir_data_d;

  logic [1:0]         full;
  logic [FRAME_W-1:0] frame0, frame1;
  logic               accept;
  logic               lane_last;
  logic               launch;

  // Ready depends on registered state only, never on sampleValidIn.
  assign sampleReadyOut = !full[wr_bank_q];
  assign firStartOut    = (state_q == START);
  assign firDataOut     = fir_data_q;
  assign pendingOut     = {1'b0, full[0]} + {1'b0, full[1]};

  fir_frame_bank #(
    .SAMPLES_NUM (SAMPLES_NUM),
    .LANE_W      (LANE_W)
  ) u_bank0 (
    .clkIn      (clkIn),
    .nResetIn   (nResetIn),
    .we_i       (accept && !wr_bank_q),
    .lane_i     (lane_cnt_q),
    .data_i     (sampleIn),
    .set_full_i (accept && lane_last && !wr_bank_q),
    .clr_full_i (launch && !rd_bank_q),
    .flush_i    (flushIn),
    .frame_o    (frame0),
    .full_o     (full[0])
  );

  fir_frame_bank #(
    .SAMPLES_NUM (SAMPLES_NUM),
    .LANE_W      (LANE_W)
  ) u_bank1 (
    .clkIn      (clkIn),
    .nResetIn   (nResetIn),
    .we_i       (accept && wr_bank_q),
    .lane_i     (lane_cnt_q),
    .data_i     (sampleIn),
    .set_full_i (accept && lane_last && wr_bank_q),
    .clr_full_i (launch && rd_bank_q),
    .flush_i    (flushIn),
    .frame_o    (frame1),
    .full_o     (full[1])
  );

  // Fill side: advance the lane counter, hop to the other bank after the last lane.
  always_comb begin
    accept     = sampleValidIn && sampleReadyOut && !flushIn;
    lane_last  = (lane_cnt_q == LANE_W'(SAMPLES_NUM - 1));
    wr_bank_d  = wr_bank_q;
    lane_cnt_d = lane_cnt_q;
    if (flushIn) begin
      wr_bank_d  = 1'b0;
      lane_cnt_d = '0;
    end else if (accept) begin
      if (lane_last) begin
        wr_bank_d  = !wr_bank_q;
        lane_cnt_d = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + LANE_W'(1);
      end
    end
  end

  // Launch FSM: capture a full bank into the output register, then pulse start for one cycle.
  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    rd_bank_d  = rd_bank_q;
    fir_data_d = fir_data_q;
    case (state_q)
      IDLE: begin
        if (!flushIn && full[rd_bank_q] && !firBusyIn) begin
          launch     = 1'b1;
          fir_data_d = rd_bank_q ? frame1 : frame0;
          rd_bank_d  = !rd_bank_q;
          state_d    = START;
        end
      end
      START:   state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flushIn) begin
      rd_bank_d = 1'b0;
    end
  end

  // State, pointers and the registered frame bus.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      state_q    <= IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      lane_cnt_q <= '0;
      fir_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      lane_cnt_q <= lane_cnt_d;
      fir_data_q <= fir_data_d;
    end
  end

endmodule

// File: tb/tb_fir_sample_packer.sv
// tb/tb_fir_sample_packer.sv - directed self-checking bench for fir_sample_packer
module tb_fir_sample_packer;

  logic        clk = 1'b0;
  logic        nreset;
  logic [15:0] sample;
  logic        valid;
  logic        ready;
  logic        flush;
  logic        busy_manual;
  logic        busy_model;
  logic        busy;
  logic        start;
  logic [63:0] data;
  logic [1:0]  pending;

  logic [15:0] s1;
  logic        v1;
  logic        r1;
  logic        flush1;
  logic        busy1;
  logic        st1;
  logic [15:0] d1;
  logic [1:0]  p1;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;

  logic        model_en = 1'b0;
  int          busy_left = 0;
  logic        sb_en = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] last_frame;
  logic        hold_chk = 1'b0;
  int          sb_started = 0;

  always #5 clk = ~clk;

  assign busy = busy_manual | busy_model;

  fir_sample_packer #(.SAMPLES_NUM(4), .SAMPLE_WIDTH(16)) dut (
    .clkIn          (clk),
    .nResetIn       (nreset),
    .sampleIn       (sample),
    .sampleValidIn  (valid),
    .sampleReadyOut (ready),
    .flushIn        (flush),
    .firBusyIn      (busy),
    .firStartOut    (start),
    .firDataOut     (data),
    .pendingOut     (pending)
  );

  fir_sample_packer #(.SAMPLES_NUM(1), .SAMPLE_WIDTH(16)) dut1 (
    .clkIn          (clk),
    .nResetIn       (nreset),
    .sampleIn       (s1),
    .sampleValidIn  (v1),
    .sampleReadyOut (r1),
    .flushIn        (flush1),
    .firBusyIn      (busy1),
    .firStartOut    (st1),
    .firDataOut     (d1),
    .pendingOut     (p1)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for the start pulse and checks the frame.
  task automatic wait_start(input string tag, input logic [63:0] exp);
    int n = 0;
    while (start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_value({tag, "_start_seen"}, {63'd0, start}, 64'd1);
    check_value({tag, "_data"}, data, exp);
  endtask

  always @(negedge clk) begin
    if (start === 1'b1) start_cnt++;
  end

  // Filter model: busy for 20 cycles after each start pulse.
  always @(negedge clk) begin
    if (!model_en || !nreset) begin
      busy_left = 0;
    end else if (start === 1'b1) begin
      busy_left = 20;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    busy_model = (busy_left > 0);
  end

  // Scoreboard: each start must carry the next expected frame, stable into HOLD.
  always @(negedge clk) begin
    if (sb_en) begin
      if (hold_chk) begin
        check_value("t3_hold_stable", data, last_frame);
        hold_chk = 1'b0;
      end
      if (start === 1'b1) begin
        sb_started++;
        if (exp_q.size() > 0) begin
          last_frame = exp_q.pop_front();
          check_value("t3_frame", data, last_frame);
          hold_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          base;
    logic [15:0] val;
    logic [63:0] cur;
    int          k;
    int          n;

    nreset = 1'b0; sample = '0; valid = 1'b0; flush = 1'b0; busy_manual = 1'b0;
    busy_model = 1'b0;
    s1 = '0; v1 = 1'b0; flush1 = 1'b0; busy1 = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check_value("rst_ready", {63'd0, ready}, 64'd1);
    check_value("rst_start", {63'd0, start}, 64'd0);
    check_value("rst_data", data, 64'd0);
    check_value("rst_pending", {62'd0, pending}, 64'd0);
    check_value("rst1_ready", {63'd0, r1}, 64'd1);
    nreset = 1'b1;
    @(negedge clk);

    // Test 1: basic frame and launch latency
    base = start_cnt;
    for (int i = 1; i <= 4; i++) begin
      sample = 16'(i); valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    check_value("t1_start_early", {63'd0, start}, 64'd0);
    check_value("t1_data_early", data, 64'd0);
    check_value("t1_pending_full", {62'd0, pending}, 64'd1);
    @(negedge clk);
    check_value("t1_data", data, 64'h0004_0003_0002_0001);
    check_value("t1_start", {63'd0, start}, 64'd1);
    check_value("t1_pending_zero", {62'd0, pending}, 64'd0);
    @(negedge clk);
    check_value("t1_start_drop", {63'd0, start}, 64'd0);
    check_value("t1_data_hold", data, 64'h0004_0003_0002_0001);
    @(negedge clk);
    check_value("t1_pulse_count", 64'(start_cnt - base), 64'd1);

    // Test 2: both banks fill while the filter is busy
    busy_manual = 1'b1;
    base = start_cnt;
    acc = 0; val = 16'd1;
    for (int c = 0; c < 12; c++) begin
      sample = val; valid = 1'b1;
      if (ready) begin acc++; val = val + 16'd1; end
      @(negedge clk);
    end
    valid = 1'b0;
    check_value("t2_accepted", 64'(acc), 64'd8);
    check_value("t2_pending", {62'd0, pending}, 64'd2);
    check_value("t2_ready_low", {63'd0, ready}, 64'd0);
    check_value("t2_no_start", 64'(start_cnt - base), 64'd0);
    busy_manual = 1'b0;
    wait_start("t2_first", 64'h0004_0003_0002_0001);
    @(negedge clk);
    wait_start("t2_second", 64'h0008_0007_0006_0005);
    check_value("t2_pending_end", {62'd0, pending}, 64'd0);
    check_value("t2_ready_back", {63'd0, ready}, 64'd1);
    @(negedge clk); @(negedge clk);

    // Test 3: filter model busy 20 cycles per frame, continuous valid, 10 frames
    model_en = 1'b1; sb_en = 1'b1; sb_started = 0;
    acc = 0; val = 16'h0100; cur = '0; k = 0; n = 0;
    while (acc < 40 && n < 3000) begin
      sample = val; valid = 1'b1;
      if (ready) begin
        cur = {val, cur[63:16]};
        k++;
        if (k == 4) begin exp_q.push_back(cur); k = 0; end
        acc++; val = val + 16'd1;
      end
      @(negedge clk);
      n++;
    end
    valid = 1'b0;
    n = 0;
    while (sb_started < 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_value("t3_accepted", 64'(acc), 64'd40);
    check_value("t3_launched", 64'(sb_started), 64'd10);
    check_value("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    check_value("t3_pending", {62'd0, pending}, 64'd0);
    sb_en = 1'b0; model_en = 1'b0;
    @(negedge clk); @(negedge clk);

    // Test 4a: flush beats a launch in the same cycle
    busy_manual = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample = 16'h0031 + 16'(i); valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    check_value("t4a_pending", {62'd0, pending}, 64'd1);
    base = start_cnt;
    flush = 1'b1; busy_manual = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check_value("t4a_pending_flushed", {62'd0, pending}, 64'd0);
    check_value("t4a_ready", {63'd0, ready}, 64'd1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check_value("t4a_no_launch", 64'(start_cnt - base), 64'd0);

    // Test 4b: partial frame discarded by flush, sample in flush cycle dropped
    sample = 16'h0055; valid = 1'b1; @(negedge clk);
    sample = 16'h0066; @(negedge clk);
    sample = 16'h0077; flush = 1'b1; @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    check_value("t4b_pending", {62'd0, pending}, 64'd0);
    check_value("t4b_ready", {63'd0, ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      sample = 16'h000A + 16'(i); valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    wait_start("t4b", 64'h000D_000C_000B_000A);
    @(negedge clk); @(negedge clk); @(negedge clk);

    // Test 5: reset in the START cycle
    for (int i = 0; i < 4; i++) begin
      sample = 16'h0011 + 16'(i); valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    wait_start("t5_pre", 64'h0014_0013_0012_0011);
    nreset = 1'b0;
    #1;
    check_value("t5_start_drop", {63'd0, start}, 64'd0);
    check_value("t5_data_rst", data, 64'd0);
    check_value("t5_pending_rst", {62'd0, pending}, 64'd0);
    check_value("t5_ready_rst", {63'd0, ready}, 64'd1);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sample = 16'h0021 + 16'(i); valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    wait_start("t5_post", 64'h0024_0023_0022_0021);
    @(negedge clk); @(negedge clk);

    // Test 6: SAMPLES_NUM=1, every sample is a frame
    s1 = 16'h8000; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    check_value("t6_start_early", {63'd0, st1}, 64'd0);
    check_value("t6_pending", {62'd0, p1}, 64'd1);
    @(negedge clk);
    check_value("t6_data", {48'd0, d1}, 64'h8000);
    check_value("t6_start", {63'd0, st1}, 64'd1);
    @(negedge clk);
    check_value("t6_start_drop", {63'd0, st1}, 64'd0);
    check_value("t6_ready", {63'd0, r1}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
